// File: rtl/ofmap_deskew_collector_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ofmap_deskew_collector_if
// Purpose  : Bundles the column-stream inputs and the aligned row-stream
//            outputs of ofmap_deskew_collector.
// Ports    : start_in / num_rows_in          - run control
//            col_valid_in / col_data_in      - skewed per-column array stream
//            row_valid_out / row_ready_in /
//            row_data_out / row_last_out     - aligned row handshake
//            done_out / err_out              - run status
// Modports : master - environment driving the collector
//            slave  - the collector itself
// Revision : 1.0 - initial release
// ============================================================================
interface ofmap_deskew_collector_if #(
  parameter int MAC_COL      = 16,
  parameter int IN_BITWIDTH  = 32,
  parameter int OUT_BITWIDTH = 16
);
  logic                              start_in;
  logic [15:0]                       num_rows_in;
  logic [MAC_COL-1:0]                col_valid_in;
  logic [MAC_COL*IN_BITWIDTH-1:0]    col_data_in;
  logic                              row_valid_out;
  logic                              row_ready_in;
  logic [MAC_COL*OUT_BITWIDTH-1:0]   row_data_out;
  logic                              row_last_out;
  logic                              done_out;
  logic                              err_out;

  modport master (
    output start_in, num_rows_in, col_valid_in, col_data_in, row_ready_in,
    input  row_valid_out, row_data_out, row_last_out, done_out, err_out
  );

  modport slave (
    input  start_in, num_rows_in, col_valid_in, col_data_in, row_ready_in,
    output row_valid_out, row_data_out, row_last_out, done_out, err_out
  );
endinterface
`default_nettype wire

// File: rtl/ofmap_deskew_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ofmap_deskew_collector
// Purpose  : Buffers each MAC-array column in its own FIFO, realigns the
//            column-skewed ofmap stream into full rows and post-processes
//            every element (arithmetic shift, optional ReLU, saturation).
// Ports    : clk  - clock
//            rst  - synchronous active-high reset
//            bus  - ofmap_deskew_collector_if.slave (column stream in,
//                   row stream out, run control and status)
// Revision : 1.0 - initial release
// ============================================================================
module ofmap_deskew_collector #(
  parameter int MAC_COL      = 16,
  parameter int IN_BITWIDTH  = 32,
  parameter int OUT_BITWIDTH = 16,
  parameter int FIFO_DEPTH   = 32,
  parameter int SHIFT        = 4,
  parameter int RELU_EN      = 0
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  ofmap_deskew_collector_if.slave    bus
);

  localparam int c_aw = $clog2(FIFO_DEPTH);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [c_aw:0] c_ptr_one = (c_aw+1)'(1);

  // Saturation bounds expressed at the input width so the comparison is
  // done before any truncation.
  localparam logic signed [IN_BITWIDTH-1:0] c_sat_max =
    {{(IN_BITWIDTH-OUT_BITWIDTH+1){1'b0}}, {(OUT_BITWIDTH-1){1'b1}}};
  localparam logic signed [IN_BITWIDTH-1:0] c_sat_min =
    {{(IN_BITWIDTH-OUT_BITWIDTH+1){1'b1}}, {(OUT_BITWIDTH-1){1'b0}}};

  // Shift (floor), optional ReLU, then clamp to the output range.
  function automatic logic [OUT_BITWIDTH-1:0] post_proc(input logic [IN_BITWIDTH-1:0] raw);
    logic signed [IN_BITWIDTH-1:0] sh;
    sh = $signed(raw) >>> SHIFT;
    if ((RELU_EN != 0) && (sh < 0)) begin
      sh = '0;
    end
    if (sh > c_sat_max) begin
      return c_sat_max[OUT_BITWIDTH-1:0];
    end else if (sh < c_sat_min) begin
      return c_sat_min[OUT_BITWIDTH-1:0];
    end
    return sh[OUT_BITWIDTH-1:0];
  endfunction

  logic [1:0]                      state_q, state_d;
  logic [15:0]                     cnt_q, cnt_d;
  logic [15:0]                     target_q, target_d;
  logic                            err_q, err_d;

  logic [MAC_COL-1:0]              empty;
  logic [MAC_COL-1:0]              full;
  logic [MAC_COL-1:0]              col_valid;
  logic [MAC_COL*IN_BITWIDTH-1:0]  col_data;
  logic [MAC_COL*OUT_BITWIDTH-1:0] row_data;

  logic in_run;
  logic start_accept;
  logic row_valid;
  logic fire;
  logic last_hit;
  logic overflow;
  logic unexpected;

  assign col_valid    = bus.col_valid_in;
  assign col_data     = bus.col_data_in;

  assign in_run       = (state_q == c_run);
  // A start is only honoured outside a run.
  assign start_accept = bus.start_in && !in_run;
  assign row_valid    = in_run && (empty == '0);
  assign fire         = row_valid && bus.row_ready_in;
  assign last_hit     = (cnt_q == (target_q - 16'd1));
  // A full column that pops on the same edge has room for the push.
  assign overflow     = in_run && !fire && ((col_valid & full) != '0);
  assign unexpected   = !in_run && !bus.start_in && (col_valid != '0);

  generate
    for (genvar c = 0; c < MAC_COL; c++) begin : g_col
      logic [c_aw:0]             wr_ptr_q, wr_ptr_d;
      logic [c_aw:0]             rd_ptr_q, rd_ptr_d;
      logic [OUT_BITWIDTH-1:0]   mem_q [FIFO_DEPTH];
      logic                      push;

      assign empty[c] = (wr_ptr_q == rd_ptr_q);
      assign full[c]  = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                        (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
      assign push     = in_run && col_valid[c] && (!full[c] || fire);

      // Gated so the row bus reads zero whenever no row is offered.
      assign row_data[c*OUT_BITWIDTH +: OUT_BITWIDTH] =
        row_valid ? mem_q[rd_ptr_q[c_aw-1:0]] : '0;

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (start_accept) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end else begin
          if (push) wr_ptr_d = wr_ptr_q + c_ptr_one;
          if (fire) rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
        end
      end

      // Storage needs no reset: it is only visible through valid pointers.
      always_ff @(posedge clk) begin
        if (push) begin
          mem_q[wr_ptr_q[c_aw-1:0]] <= post_proc(col_data[c*IN_BITWIDTH +: IN_BITWIDTH]);
        end
      end
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    err_d    = err_q;
    if (start_accept) begin
      cnt_d    = '0;
      target_d = bus.num_rows_in;
      err_d    = 1'b0;
      state_d  = (bus.num_rows_in == 16'd0) ? c_done : c_run;
    end else begin
      if (fire) begin
        cnt_d = cnt_q + 16'd1;
        if (last_hit) state_d = c_done;
      end
      if (overflow || unexpected) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= c_idle;
      cnt_q    <= '0;
      target_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      err_q    <= err_d;
    end
  end

  assign bus.row_valid_out = row_valid;
  assign bus.row_data_out  = row_data;
  assign bus.row_last_out  = row_valid && last_hit;
  assign bus.done_out      = (state_q == c_done);
  assign bus.err_out       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ofmap_deskew_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ofmap_deskew_collector
// Purpose  : Self-checking bench for ofmap_deskew_collector. Two DUTs (ReLU
//            off / on) receive identical stimulus; a scoreboard queue holds
//            the expected rows and a negedge monitor checks every offered row.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofmap_deskew_collector;
  localparam int MAC_COL = 16;
  localparam int IN_BW   = 32;
  localparam int OUT_BW  = 16;
  localparam int RW      = MAC_COL*OUT_BW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ofmap_deskew_collector_if #(.MAC_COL(MAC_COL), .IN_BITWIDTH(IN_BW), .OUT_BITWIDTH(OUT_BW)) bus ();
  ofmap_deskew_collector_if #(.MAC_COL(MAC_COL), .IN_BITWIDTH(IN_BW), .OUT_BITWIDTH(OUT_BW)) relu_bus ();

  assign relu_bus.start_in     = bus.start_in;
  assign relu_bus.num_rows_in  = bus.num_rows_in;
  assign relu_bus.col_valid_in = bus.col_valid_in;
  assign relu_bus.col_data_in  = bus.col_data_in;
  assign relu_bus.row_ready_in = bus.row_ready_in;

  ofmap_deskew_collector #(.MAC_COL(MAC_COL), .IN_BITWIDTH(IN_BW), .OUT_BITWIDTH(OUT_BW),
    .FIFO_DEPTH(32), .SHIFT(4), .RELU_EN(0)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  ofmap_deskew_collector #(.MAC_COL(MAC_COL), .IN_BITWIDTH(IN_BW), .OUT_BITWIDTH(OUT_BW),
    .FIFO_DEPTH(32), .SHIFT(4), .RELU_EN(1)) u_relu (.clk(clk), .rst(rst), .bus(relu_bus));

  typedef struct packed {
    logic [RW-1:0] m;
    logic [RW-1:0] r;
    logic          last;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] vec [0:63][0:MAC_COL-1];

  // Reference: floor-divide by 16 using remainder correction, then clamp.
  function automatic logic [15:0] model(logic [31:0] raw, bit relu);
    longint v, rem;
    v   = longint'($signed(raw));
    rem = v % 16;
    if (rem < 0) rem = rem + 16;
    v = (v - rem) / 16;
    if (relu && v < 0) v = 0;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic chk1(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkw(string name, logic [RW-1:0] act, logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(int r, bit last);
    exp_t e;
    for (int c = 0; c < MAC_COL; c++) begin
      e.m[c*OUT_BW +: OUT_BW] = model(vec[r][c], 1'b0);
      e.r[c*OUT_BW +: OUT_BW] = model(vec[r][c], 1'b1);
    end
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic start_run(int n);
    @(posedge clk); #1;
    bus.start_in     = 1'b1;
    bus.num_rows_in  = 16'(n);
    bus.col_valid_in = '0;
  endtask

  // Column c carries row k-c at cycle k when skewed, row k otherwise.
  task automatic feed(int nrows, bit skew, bit chk_first, int err0_k, int start_k);
    int ncyc;
    logic [MAC_COL-1:0]       v;
    logic [MAC_COL*IN_BW-1:0] d;
    ncyc = nrows + (skew ? MAC_COL-1 : 0);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      for (int c = 0; c < MAC_COL; c++) begin
        int r;
        r = skew ? k - c : k;
        if (r >= 0 && r < nrows) begin
          v[c] = 1'b1;
          d[c*IN_BW +: IN_BW] = vec[r][c];
        end else begin
          v[c] = 1'b0;
          d[c*IN_BW +: IN_BW] = '0;
        end
      end
      bus.start_in     = (k == start_k);
      if (k == start_k) bus.num_rows_in = 16'd4;
      bus.col_valid_in = v;
      bus.col_data_in  = d;
      if (chk_first && k == MAC_COL-1) chk1("first_valid_early", bus.row_valid_out, 1'b0);
      if (chk_first && k == MAC_COL)   chk1("first_valid", bus.row_valid_out, 1'b1);
      if (k == err0_k) chk1("err_before_overflow", bus.err_out, 1'b0);
    end
    @(posedge clk); #1;
    bus.start_in     = 1'b0;
    bus.col_valid_in = '0;
    bus.col_data_in  = '0;
  endtask

  task automatic wait_done(int budget);
    int i;
    i = 0;
    while (!bus.done_out && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    chk1("done_reached", bus.done_out, 1'b1);
    chk1("sb_drained", sb.size() == 0, 1'b1);
  endtask

  task automatic chk_idle_outputs(string tag);
    chk1({tag, "_valid"}, bus.row_valid_out, 1'b0);
    chk1({tag, "_last"},  bus.row_last_out,  1'b0);
    chk1({tag, "_done"},  bus.done_out,      1'b0);
    chk1({tag, "_err"},   bus.err_out,       1'b0);
    chkw({tag, "_data"},  bus.row_data_out,  '0);
  endtask

  // Monitor: every offered row is checked against the scoreboard head;
  // stalled rows are re-checked each cycle, accepted rows are popped.
  always @(negedge clk) begin
    if (!rst && bus.row_valid_out) begin
      if (sb.size() == 0) begin
        if (bus.row_ready_in) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_row: got row %h expected none (t=%0t)", bus.row_data_out, $time);
        end
      end else begin
        chkw("row_data", bus.row_data_out, sb[0].m);
        chkw("row_data_relu", relu_bus.row_data_out, sb[0].r);
        chk1("row_last", bus.row_last_out, sb[0].last);
        chk1("relu_valid", relu_bus.row_valid_out, 1'b1);
        if (bus.row_ready_in) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bus.start_in     = 1'b0;
    bus.num_rows_in  = '0;
    bus.col_valid_in = '0;
    bus.col_data_in  = '0;
    bus.row_ready_in = 1'b0;

    // Reset state and unexpected push from IDLE
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;
    bus.col_valid_in = 16'h0001;
    @(posedge clk); #1;
    bus.col_valid_in = '0;
    chk1("idle_push_err", bus.err_out, 1'b1);

    // Skewed stream, 4 rows, always ready: lanes 0x0123/0133/0143/0153
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < MAC_COL; c++) vec[r][c] = 32'h0000_1234 + 32'h100 * r;
    for (int r = 0; r < 4; r++) push_exp(r, r == 3);
    bus.row_ready_in = 1'b1;
    start_run(4);
    feed(4, 1'b1, 1'b1, -1, -1);
    chk1("skew_last_valid", bus.row_valid_out, 1'b1);
    chk1("skew_last_flag", bus.row_last_out, 1'b1);
    chk1("skew_err_cleared", bus.err_out, 1'b0);
    @(posedge clk); #1;
    chk1("skew_done", bus.done_out, 1'b1);
    chk1("skew_sb_drained", sb.size() == 0, 1'b1);

    // Arithmetic corners, hand-computed for SHIFT=4 (ReLU off / on)
    for (int c = 0; c < MAC_COL; c++) vec[0][c] = '0;
    e = '0;
    vec[0][0]  = 32'h7FFF_FFFF; e.m[0*16 +: 16]  = 16'h7FFF; e.r[0*16 +: 16]  = 16'h7FFF;
    vec[0][1]  = 32'h8000_0000; e.m[1*16 +: 16]  = 16'h8000; e.r[1*16 +: 16]  = 16'h0000;
    vec[0][2]  = 32'hFFFF_FF00; e.m[2*16 +: 16]  = 16'hFFF0; e.r[2*16 +: 16]  = 16'h0000;
    vec[0][3]  = 32'h0000_000F; e.m[3*16 +: 16]  = 16'h0000; e.r[3*16 +: 16]  = 16'h0000;
    vec[0][4]  = 32'h0010_0000; e.m[4*16 +: 16]  = 16'h7FFF; e.r[4*16 +: 16]  = 16'h7FFF;
    vec[0][5]  = 32'hFFF0_0000; e.m[5*16 +: 16]  = 16'h8000; e.r[5*16 +: 16]  = 16'h0000;
    vec[0][6]  = 32'hFFFF_FFFF; e.m[6*16 +: 16]  = 16'hFFFF; e.r[6*16 +: 16]  = 16'h0000;
    vec[0][7]  = 32'h0000_7FF0; e.m[7*16 +: 16]  = 16'h07FF; e.r[7*16 +: 16]  = 16'h07FF;
    vec[0][8]  = 32'h0007_FFF0; e.m[8*16 +: 16]  = 16'h7FFF; e.r[8*16 +: 16]  = 16'h7FFF;
    vec[0][9]  = 32'hFFF8_0000; e.m[9*16 +: 16]  = 16'h8000; e.r[9*16 +: 16]  = 16'h0000;
    vec[0][10] = 32'hFFF7_FFF0; e.m[10*16 +: 16] = 16'h8000; e.r[10*16 +: 16] = 16'h0000;
    e.last = 1'b1;
    sb.push_back(e);
    start_run(1);
    feed(1, 1'b0, 1'b0, -1, -1);
    wait_done(10);
    chk1("arith_err", bus.err_out, 1'b0);

    // Backpressure: 8 skewed rows, 10 stall cycles from first valid
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < MAC_COL; c++)
        vec[r][c] = (c % 2 == 1) ? -((r << 12) | (c << 4)) : ((r << 12) | (c << 4));
    for (int r = 0; r < 8; r++) push_exp(r, r == 7);
    bus.row_ready_in = 1'b0;
    start_run(8);
    feed(8, 1'b1, 1'b0, -1, -1);
    chk1("bp_stalled_valid", bus.row_valid_out, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    bus.row_ready_in = 1'b1;
    wait_done(30);
    chk1("bp_err", bus.err_out, 1'b0);

    // Overflow: 33 unskewed pushes into 32-deep FIFOs with no pops
    for (int r = 0; r < 33; r++)
      for (int c = 0; c < MAC_COL; c++) vec[r][c] = (r << 4) | (c << 12);
    for (int r = 0; r < 32; r++) push_exp(r, r == 31);
    bus.row_ready_in = 1'b0;
    start_run(32);
    feed(33, 1'b0, 1'b0, 32, -1);
    chk1("ovf_err", bus.err_out, 1'b1);
    bus.row_ready_in = 1'b1;
    wait_done(60);
    chk1("ovf_err_sticky", bus.err_out, 1'b1);

    // Zero-row run
    start_run(0);
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    chk1("zero_done", bus.done_out, 1'b1);
    chk1("zero_err_cleared", bus.err_out, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk1("zero_no_valid", bus.row_valid_out, 1'b0);
      @(posedge clk); #1;
    end

    // Start pulse (num_rows_in=4) during a 6-row run is ignored
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < MAC_COL; c++) vec[r][c] = 32'h0001_0000 + (r << 8) + (c << 4);
    for (int r = 0; r < 6; r++) push_exp(r, r == 5);
    start_run(6);
    feed(6, 1'b1, 1'b0, -1, 5);
    chk1("ign_last_flag", bus.row_last_out, 1'b1);
    wait_done(5);

    // Reset mid-traffic, then unexpected push from IDLE
    bus.row_ready_in = 1'b0;
    start_run(4);
    @(posedge clk); #1;
    bus.start_in     = 1'b0;
    bus.col_valid_in = '1;
    bus.col_data_in  = '1;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    chk_idle_outputs("midrst");
    bus.col_valid_in = 16'h0001;
    @(posedge clk); #1;
    bus.col_valid_in = '0;
    bus.col_data_in  = '0;
    chk1("midrst_push_err", bus.err_out, 1'b1);
    chk1("midrst_no_valid", bus.row_valid_out, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ofmap_deskew_collector.md
Name: ofmap_deskew_collector

Overview:
- Sits directly downstream of the MAC array and consumes its per-column ofmap stream (ofmap_valid_out / ofmap_data_out).
- The array emits column c one cycle later than column c-1, and it has no backpressure. This block buffers each column in its own FIFO and realigns the columns into full output rows.
- Each element is post-processed (arithmetic shift, optional ReLU, saturation) before it leaves the block.
- The result is an aligned row-vector stream with a valid/ready handshake, feeding the ofmap writeback buffer.

Parameters:
- MAC_COL, 16, number of array columns (lanes per output row)
- IN_BITWIDTH, 32, signed accumulator width from the array
- OUT_BITWIDTH, 16, signed output element width
- FIFO_DEPTH, 32, entries per column FIFO; power of 2; must be >= 2*MAC_COL
- SHIFT, 4, arithmetic right shift applied before saturation (0..IN_BITWIDTH-1)
- RELU_EN, 0, 1 = clamp negative results to 0

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start_in  in  1  one-cycle pulse; latches num_rows_in and arms collection
- num_rows_in  in  16  number of output rows expected in this run
- col_valid_in  in  MAC_COL  per-column valid (array ofmap_valid_out)
- col_data_in  in  MAC_COL*IN_BITWIDTH  per-column accumulator, column c at bits [c*IN_BITWIDTH +: IN_BITWIDTH]
- row_valid_out  out  1  aligned row available
- row_ready_in  in  1  downstream accepts row
- row_data_out  out  MAC_COL*OUT_BITWIDTH  processed row, lane c at bits [c*OUT_BITWIDTH +: OUT_BITWIDTH]
- row_last_out  out  1  qualifies the final row of a run
- done_out  out  1  level; run complete
- err_out  out  1  sticky; overflow or unexpected push

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state=IDLE
  - all FIFOs empty
  - row counter=0
  - row_valid_out=0, row_last_out=0, done_out=0, err_out=0
  - row_data_out=0
- Reset mid-run aborts the run immediately; buffered data is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start_in--> RUN (num_rows_in!=0) or DONE (num_rows_in==0).
  - RUN --(row fires and counter==target-1)--> DONE.
  - DONE --start_in--> RUN/DONE by the same rule as IDLE.
- On an accepted start_in:
  - FIFOs are flushed, the counter is cleared, err_out is cleared and done_out is cleared.
  - target is latched from num_rows_in.
- start_in during RUN is ignored.
- Push: in RUN, col_valid_in[c]=1 writes col_data_in lane c into FIFO c. Each column is independent; skew of any amount is tolerated within the FIFO depth.
- Data written at edge t is visible at the FIFO head at t+1. No combinational path from col_valid_in to row_valid_out.
- row_valid_out = (state==RUN) AND all MAC_COL FIFOs non-empty.
- Fire = row_valid_out & row_ready_in. A fire pops every FIFO on the same edge and increments the counter.
- row_data_out is combinational from the FIFO heads and must hold stable while row_valid_out=1 and row_ready_in=0.
- Push and pop on the same edge to a full FIFO is legal: occupancy is unchanged and no error is raised.
- Overflow: a push to a full FIFO with no simultaneous pop drops the incoming element (existing contents intact) and sets err_out.
- Unexpected push: col_valid_in[c]=1 while in IDLE or DONE is dropped and sets err_out.
- row_last_out = row_valid_out AND (counter==target-1).
- done_out goes high the cycle after the last fire and stays high until start_in or rst.
- Per-lane arithmetic, in order:
  1. Interpret the lane as signed IN_BITWIDTH.
  2. Arithmetic right shift by SHIFT (floor; no rounding).
  3. If RELU_EN and the result is negative, force it to 0.
  4. Saturate to [-2^(OUT_BITWIDTH-1), 2^(OUT_BITWIDTH-1)-1].
- Counter and target are 16 bits; the counter never wraps because the transition to DONE occurs at target.

Test Plan:
- Reset values: assert rst for 3 cycles mid-traffic -> next cycle all outputs 0, state IDLE; a subsequent push with col_valid_in=16'h0001 sets err_out=1 the following cycle.
- Skewed stream: start with num_rows_in=4; drive column c valid at cycles t+c..t+c+3 with data 0x00001234 + 0x100*row -> first row_valid_out at t+16 (row_ready_in=1); lane data 0x0123, 0x0133, 0x0143, 0x0153 on consecutive rows; row_last_out on the 4th row; done_out=1 the cycle after.
- Arithmetic (SHIFT=4): 0x7FFFFFFF -> 0x7FFF; 0x80000000 -> 0x8000; 0xFFFFFF00 -> 0xFFF0 with RELU_EN=0 and 0x0000 with RELU_EN=1; 0x0000000F -> 0x0000.
- Backpressure: num_rows_in=8; hold row_ready_in=0 for 10 cycles after the first row becomes valid -> row_valid_out stays 1 with constant data; all 8 rows are delivered in order after release and err_out stays 0.
- Overflow: FIFO_DEPTH=32, row_ready_in=0; push 33 consecutive elements to all columns -> err_out=1 one cycle after the 33rd push; after release the 32 rows out are elements 0..31 and element 32 is absent.
- Zero-row and ignored start: start with num_rows_in=0 -> done_out=1 next cycle, row_valid_out never asserts; a start_in pulse mid-run with num_rows_in=4 -> target unchanged, run completes at the original count.
